// File: rtl/idma_axis_read.sv
// -----------------------------------------------------------------------------
// idma_axis_read
//
// Read side of an iDMA backend whose source is an AXI Stream. Each stream beat
// is masked to the byte window requested by the datapath (offset .. tailer),
// rotated by the shift amount and pushed lane-by-lane into the dataflow
// buffer. At the same time a per-beat response is returned to the datapath.
// The beat, the datapath request and the read meta request are consumed
// together once both the buffer push (BUF) and the response (RSP) have
// completed. Either branch may complete in an earlier cycle than the other.
// The datapath itself is purely combinational, so a beat can be fully
// consumed in the cycle it is presented.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   r_dp_offset_i        first valid byte lane of the beat
//   r_dp_tailer_i        last valid lane + 1 (0: all lanes up to the top)
//   r_dp_shift_i         lane rotation applied into the buffer
//   r_dp_req_valid_i/
//   r_dp_req_ready_o     datapath request handshake
//   r_dp_rsp_*           datapath response (resp, first, last, valid/ready)
//   ar_valid_i/
//   ar_ready_o           read meta request handshake
//   dp_poison_i          complete the buffer branch without pushing
//   axis_t*              AXI Stream input
//   buffer_in_o          rotated bytes towards the dataflow buffer
//   buffer_in_valid_o    per-lane push valid
//   buffer_in_ready_i    per-lane buffer ready
// -----------------------------------------------------------------------------
module idma_axis_read #(
    parameter int unsigned StrbWidth   = 16,
    parameter int unsigned OffsetWidth = $clog2(StrbWidth)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic [OffsetWidth-1:0]   r_dp_offset_i,
    input  logic [OffsetWidth-1:0]   r_dp_tailer_i,
    input  logic [OffsetWidth-1:0]   r_dp_shift_i,
    input  logic                     r_dp_req_valid_i,
    output logic                     r_dp_req_ready_o,

    output logic [1:0]               r_dp_rsp_resp_o,
    output logic                     r_dp_rsp_first_o,
    output logic                     r_dp_rsp_last_o,
    output logic                     r_dp_rsp_valid_o,
    input  logic                     r_dp_rsp_ready_i,

    input  logic                     ar_valid_i,
    output logic                     ar_ready_o,

    input  logic                     dp_poison_i,

    input  logic [8*StrbWidth-1:0]   axis_tdata_i,
    input  logic [StrbWidth-1:0]     axis_tkeep_i,
    input  logic                     axis_tlast_i,
    input  logic                     axis_tvalid_i,
    output logic                     axis_tready_o,

    output logic [8*StrbWidth-1:0]   buffer_in_o,
    output logic [StrbWidth-1:0]     buffer_in_valid_o,
    input  logic [StrbWidth-1:0]     buffer_in_ready_i
);

    localparam int unsigned DataWidth = 8 * StrbWidth;

    typedef logic [StrbWidth-1:0] strb_t;
    typedef logic [DataWidth-1:0] data_t;

    localparam strb_t AllOnes = '1;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    // -------------------------------------------------------------------------
    // Byte-lane masks
    // -------------------------------------------------------------------------
    strb_t mask_lo;
    strb_t mask_hi;
    strb_t mask_in;
    strb_t mask_rot;

    // Lanes at or above the offset.
    assign mask_lo = AllOnes << r_dp_offset_i;

    // Lanes below the tailer; a zero tailer means the window runs to the top
    // lane, which is not representable as StrbWidth in OffsetWidth bits.
    assign mask_hi = (r_dp_tailer_i != '0)
                   ? (AllOnes >> (StrbWidth - int'(r_dp_tailer_i)))
                   : AllOnes;

    assign mask_in = mask_lo & mask_hi;

    // Rotate-left by shift: shifting a doubled copy left and keeping the upper
    // half wraps the bits that leave the top back in at the bottom.
    logic [2*StrbWidth-1:0] mask_dbl;
    assign mask_dbl = {mask_in, mask_in} << r_dp_shift_i;
    assign mask_rot = mask_dbl[2*StrbWidth-1 -: StrbWidth];

    // -------------------------------------------------------------------------
    // Data rotation: byte i lands on lane (i + shift) mod StrbWidth
    // -------------------------------------------------------------------------
    logic [2*DataWidth-1:0] data_dbl;
    assign data_dbl    = {axis_tdata_i, axis_tdata_i} << {r_dp_shift_i, 3'b000};
    assign buffer_in_o = data_t'(data_dbl[2*DataWidth-1 -: DataWidth]);

    // -------------------------------------------------------------------------
    // Handshake fork state
    // -------------------------------------------------------------------------
    logic done_buf;
    logic done_rsp;
    logic first_q;

    logic beat_pending;
    logic buf_valid;
    logic buf_hs;
    logic rsp_hs;
    logic all_done;
    logic consume;

    // NOTE: every signal driven from always_comb receives a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        beat_pending      = 1'b0;
        buf_valid         = 1'b0;
        buf_hs            = 1'b0;
        rsp_hs            = 1'b0;
        all_done          = 1'b0;
        consume           = 1'b0;
        buffer_in_valid_o = '0;
        r_dp_rsp_valid_o  = 1'b0;

        beat_pending = ar_valid_i & r_dp_req_valid_i & axis_tvalid_i;

        // BUF branch: a poisoned beat completes without presenting any lane,
        // otherwise every lane of the rotated mask must be ready at once.
        buf_valid = beat_pending & ~done_buf;
        if (buf_valid && !dp_poison_i) begin
            buffer_in_valid_o = mask_rot;
        end
        buf_hs = buf_valid &
                 (dp_poison_i | ((buffer_in_ready_i & mask_rot) == mask_rot));

        // RSP branch.
        r_dp_rsp_valid_o = beat_pending & ~done_rsp;
        rsp_hs           = r_dp_rsp_valid_o & r_dp_rsp_ready_i;

        all_done = (done_buf | buf_hs) & (done_rsp | rsp_hs);
        consume  = beat_pending & all_done;
    end

    // The three upstream channels are released together when the fork joins.
    assign axis_tready_o    = consume;
    assign r_dp_req_ready_o = consume;
    assign ar_ready_o       = consume;

    // -------------------------------------------------------------------------
    // Response fields: derived from the held beat and first_q, both of which
    // stay constant until the beat is consumed, so they are stable while the
    // response is pending.
    // -------------------------------------------------------------------------
    assign r_dp_rsp_resp_o  = ((axis_tkeep_i & mask_in) != mask_in) ? RespSlverr
                                                                     : RespOkay;
    assign r_dp_rsp_last_o  = axis_tlast_i;
    assign r_dp_rsp_first_o = first_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            done_buf <= 1'b0;
            done_rsp <= 1'b0;
            first_q  <= 1'b1;
        end else if (consume) begin
            done_buf <= 1'b0;
            done_rsp <= 1'b0;
            // The beat after a tlast starts a new packet.
            first_q  <= axis_tlast_i;
        end else begin
            // Partial completion is remembered; if the beat is withdrawn
            // mid-fork no handshake can occur and the flags simply hold.
            if (buf_hs) done_buf <= 1'b1;
            if (rsp_hs) done_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_idma_axis_read.sv
// -----------------------------------------------------------------------------
// tb_idma_axis_read
//
// Directed bench for idma_axis_read with StrbWidth = 8. Expected responses are
// queued when a beat is driven and popped whenever the DUT completes a
// response handshake. Buffer-side outputs and the upstream readies are
// compared directly on the falling edge.
// -----------------------------------------------------------------------------
module tb_idma_axis_read;

    localparam int unsigned S  = 8;
    localparam int unsigned OW = 3;

    logic            clk;
    logic            rst_n;
    logic [OW-1:0]   offset;
    logic [OW-1:0]   tailer;
    logic [OW-1:0]   shift;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      rsp_resp;
    logic            rsp_first;
    logic            rsp_last;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            ar_valid;
    logic            ar_ready;
    logic            poison;
    logic [8*S-1:0]  tdata;
    logic [S-1:0]    tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready;
    logic [8*S-1:0]  buf_data;
    logic [S-1:0]    buf_valid;
    logic [S-1:0]    buf_ready;

    idma_axis_read #(
        .StrbWidth  (S),
        .OffsetWidth(OW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .r_dp_offset_i    (offset),
        .r_dp_tailer_i    (tailer),
        .r_dp_shift_i     (shift),
        .r_dp_req_valid_i (req_valid),
        .r_dp_req_ready_o (req_ready),
        .r_dp_rsp_resp_o  (rsp_resp),
        .r_dp_rsp_first_o (rsp_first),
        .r_dp_rsp_last_o  (rsp_last),
        .r_dp_rsp_valid_o (rsp_valid),
        .r_dp_rsp_ready_i (rsp_ready),
        .ar_valid_i       (ar_valid),
        .ar_ready_o       (ar_ready),
        .dp_poison_i      (poison),
        .axis_tdata_i     (tdata),
        .axis_tkeep_i     (tkeep),
        .axis_tlast_i     (tlast),
        .axis_tvalid_i    (tvalid),
        .axis_tready_o    (tready),
        .buffer_in_o      (buf_data),
        .buffer_in_valid_o(buf_valid),
        .buffer_in_ready_i(buf_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] resp;
        logic       first;
        logic       last;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t exp_e;
    int   checks   = 0;
    int   failures = 0;
    logic exp_first;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference window: lane i valid when offset <= i < tailer (0 = top).
    function automatic logic [S-1:0] ref_mask(input logic [OW-1:0] off,
                                              input logic [OW-1:0] tail);
        logic [S-1:0] m;
        m = '0;
        for (int i = 0; i < S; i++)
            m[i] = (i >= int'(off)) && ((tail == 0) || (i < int'(tail)));
        return m;
    endfunction

    function automatic logic [S-1:0] ref_rot(input logic [S-1:0] m,
                                             input logic [OW-1:0] sh);
        logic [S-1:0] r;
        r = '0;
        for (int i = 0; i < S; i++) r[(i + int'(sh)) % S] = m[i];
        return r;
    endfunction

    function automatic logic [8*S-1:0] ref_data(input logic [8*S-1:0] d,
                                                input logic [OW-1:0] sh);
        logic [8*S-1:0] r;
        r = '0;
        for (int i = 0; i < S; i++) r[8*((i + int'(sh)) % S) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Scoreboard: every completed response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check("rsp_resp",  64'(rsp_resp),  64'(exp_e.resp));
                check("rsp_first", 64'(rsp_first), 64'(exp_e.first));
                check("rsp_last",  64'(rsp_last),  64'(exp_e.last));
            end
        end
    end

    task automatic drive_beat(input logic [OW-1:0] off, input logic [OW-1:0] tail,
                              input logic [OW-1:0] sh, input logic [8*S-1:0] d,
                              input logic [S-1:0] keep, input logic last,
                              input logic poi);
        rsp_t e;
        offset    = off;
        tailer    = tail;
        shift     = sh;
        tdata     = d;
        tkeep     = keep;
        tlast     = last;
        poison    = poi;
        req_valid = 1'b1;
        ar_valid  = 1'b1;
        tvalid    = 1'b1;
        e.resp    = ((keep & ref_mask(off, tail)) != ref_mask(off, tail)) ? 2'b10 : 2'b00;
        e.first   = exp_first;
        e.last    = last;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        ar_valid  = 1'b0;
        tvalid    = 1'b0;
        poison    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_readies(input string tag, input logic exp);
        check({tag, "_tready"},    64'(tready),    64'(exp));
        check({tag, "_req_ready"}, 64'(req_ready), 64'(exp));
        check({tag, "_ar_ready"},  64'(ar_ready),  64'(exp));
    endtask

    logic [8*S-1:0] rnd_data;
    logic [OW-1:0]  rnd_off;
    logic [OW-1:0]  rnd_sh;

    initial begin
        rst_n     = 1'b0;
        offset    = '0;
        tailer    = '0;
        shift     = '0;
        tdata     = '0;
        tkeep     = '0;
        tlast     = 1'b0;
        buf_ready = '1;
        rsp_ready = 1'b1;
        exp_first = 1'b1;
        idle();

        // Reset with idle inputs: every valid/ready output low.
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_buf_valid", 64'(buf_valid), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check_readies("rst", 1'b0);
        next_cycle();
        rst_n = 1'b1;

        // Windowed beat, everything ready: consumed in one cycle.
        drive_beat(3'd2, 3'd6, 3'd0, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        check("win_buf_valid", 64'(buf_valid), 64'h3C);
        check("win_rsp_valid", 64'(rsp_valid), 64'h1);
        check_readies("win", 1'b1);
        next_cycle();
        exp_first = 1'b0;

        // Full window rotated by 3.
        drive_beat(3'd0, 3'd0, 3'd3, 64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        check("rot_buf_valid", 64'(buf_valid), 64'(ref_rot(8'hFF, 3'd3)));
        check("rot_data",      buf_data,       ref_data(64'h0706050403020100, 3'd3));
        check("rot_lane3",     64'(buf_data[24 +: 8]), 64'h00);
        check("rot_lane0",     64'(buf_data[0 +: 8]),  64'h05);
        check_readies("rot", 1'b1);
        next_cycle();

        // Partial buffer ready: response goes first, beat waits for the lanes.
        buf_ready = 8'h0F;
        drive_beat(3'd2, 3'd6, 3'd0, 64'hA0A1A2A3A4A5A6A7, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        check("part0_buf_valid", 64'(buf_valid), 64'h3C);
        check("part0_rsp_valid", 64'(rsp_valid), 64'h1);
        check_readies("part0", 1'b0);
        next_cycle();
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            check("partn_rsp_valid", 64'(rsp_valid), 64'h0);
            check("partn_buf_valid", 64'(buf_valid), 64'h3C);
            check("partn_tready",    64'(tready),    64'h0);
            next_cycle();
        end
        buf_ready = 8'hFF;
        @(negedge clk);
        check("part3_rsp_valid", 64'(rsp_valid), 64'h0);
        check_readies("part3", 1'b1);
        next_cycle();
        exp_first = 1'b1;

        // Missing keep bytes: SLVERR but still consumed.
        drive_beat(3'd0, 3'd0, 3'd0, 64'h0, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        check("err_rsp_valid", 64'(rsp_valid), 64'h1);
        check_readies("err", 1'b1);
        next_cycle();
        exp_first = 1'b1;

        // Packet framing: tlast 0,0,1 then a fresh packet.
        for (int b = 0; b < 4; b++) begin
            rnd_data = {$urandom, $urandom};
            rnd_off  = OW'($urandom_range(0, 3));
            rnd_sh   = OW'($urandom_range(0, 7));
            drive_beat(rnd_off, 3'd0, rnd_sh, rnd_data, 8'hFF, (b == 2), 1'b0);
            @(negedge clk);
            check("pkt_buf_valid", 64'(buf_valid),
                  64'(ref_rot(ref_mask(rnd_off, 3'd0), rnd_sh)));
            check("pkt_data", buf_data, ref_data(rnd_data, rnd_sh));
            check("pkt_tready", 64'(tready), 64'h1);
            next_cycle();
            exp_first = (b == 2);
        end

        // Poisoned beat: no push even with the buffer stalled, still consumed.
        buf_ready = 8'h00;
        drive_beat(3'd1, 3'd5, 3'd2, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        check("poi_buf_valid", 64'(buf_valid), 64'h0);
        check("poi_rsp_valid", 64'(rsp_valid), 64'h1);
        check_readies("poi", 1'b1);
        next_cycle();
        exp_first = 1'b1;

        // Reset in the middle of a fork: response done, buffer stalled.
        drive_beat(3'd2, 3'd6, 3'd0, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        check("mid0_rsp_valid", 64'(rsp_valid), 64'h1);
        check("mid0_tready",    64'(tready),    64'h0);
        next_cycle();
        @(negedge clk);
        check("mid1_rsp_valid", 64'(rsp_valid), 64'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tready", 64'(tready), 64'h0);
        next_cycle();
        rst_n = 1'b1;
        // Beat is re-presented: response again, first restored by reset.
        exp_first = 1'b1;
        exp_e.resp  = 2'b00;
        exp_e.first = 1'b1;
        exp_e.last  = 1'b0;
        exp_q.push_back(exp_e);
        buf_ready = 8'hFF;
        @(negedge clk);
        check("post_rsp_valid", 64'(rsp_valid), 64'h1);
        check("post_buf_valid", 64'(buf_valid), 64'h3C);
        check("post_data",      buf_data,       ref_data(64'h0123456789ABCDEF, 3'd0));
        check_readies("post", 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        check("idle_rsp_valid", 64'(rsp_valid), 64'h0);
        check("sb_drained",     64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
